// File: rtl/rv32i_pkg.sv
// Shared types and widths for the rv32i memory-side blocks.
package rv32i_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } resp_owner_t;

  // Who receives mem_rdata next cycle; a fetch flushed on its grant cycle is
  // never tracked, and stores produce no response.
  function automatic resp_owner_t next_owner(input logic fetch_gnt,
                                             input logic flush,
                                             input logic load_gnt);
    if (fetch_gnt && !flush) begin
      return OWN_FETCH;
    end else if (load_gnt) begin
      return OWN_DATA;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/rv32i_streakCounter.sv
// Saturating counter of consecutive contested data grants; at_max forces the
// next contested cycle to the fetch port.
module rv32i_streakCounter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_C);

endmodule

// File: rtl/rv32i_memarbiter.sv
// Arbitrates the single-port instruction/data memory between fetch and
// load/store, routing the one-cycle-latency read data back to its requester.
module rv32i_memarbiter
  import rv32i_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  resp_owner_t resp_owner;
  logic        streak_max;
  logic        if_gnt_c;
  logic        d_gnt_c;

  // Data wins contention unless its streak has hit the limit.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!reset) begin
      if (d_req && if_req) begin
        if (streak_max) begin
          if_gnt_c = 1'b1;
        end else begin
          d_gnt_c = 1'b1;
        end
      end else if (d_req) begin
        d_gnt_c = 1'b1;
      end else if (if_req) begin
        if_gnt_c = 1'b1;
      end
    end
  end

  assign if_gnt = if_gnt_c;
  assign d_gnt  = d_gnt_c;
  assign mem_en = if_gnt_c | d_gnt_c;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt_c) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt_c) begin
      mem_be   = 4'b1111;
      mem_addr = if_addr;
    end
  end

  rv32i_streakCounter #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .inc   (d_gnt_c & if_req),
    .clr   (if_gnt_c | ~if_req),
    .at_max(streak_max)
  );

  // Grant stage -> response stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= next_owner(if_gnt_c, if_flush, d_gnt_c & ~d_we);
    end
  end

  assign if_rvalid = ~reset & (resp_owner == OWN_FETCH) & ~if_flush;
  assign d_rvalid  = ~reset & (resp_owner == OWN_DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_rv32i_memarbiter.sv
// Directed bench for rv32i_memarbiter with a small byte-enabled memory model.
module tb_rv32i_memarbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:63];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_memarbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | i;
    mem[4]  = 32'h00500093;
    mem[16] = 32'h12345678;

    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; if_flush = 1'b0;
    if_addr = 30'h0; d_we = 1'b0; d_be = 4'h0; d_addr = 30'h0; d_wdata = 32'h0;
    settle;
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    tick; tick;
    chk("rst_hold_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);

    // First fetch after reset
    reset = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 30'h4;
    settle;
    chk("f1_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("f1_mem_addr", {2'b0, mem_addr}, 32'h4);
    chk("f1_mem_we_be", {27'b0, mem_we, mem_be}, 32'h0F);
    chk("f1_if_rvalid_early", {31'b0, if_rvalid}, 32'd0);
    tick;
    if_req = 1'b0;
    settle;
    chk("f1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("f1_if_rdata", if_rdata, 32'h00500093);
    chk("f1_mem_en_idle", {31'b0, mem_en}, 32'd0);

    // Contention: 4 data grants then one forced fetch
    tick;
    if_req = 1'b1; if_addr = 30'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h8;
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("cont%0d_if_gnt", i), {31'b0, if_gnt}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_d_gnt", i), {31'b0, d_gnt}, (i == 4 || i == 9) ? 32'd0 : 32'd1);
      chk($sformatf("cont%0d_d_rvalid", i), {31'b0, d_rvalid},
          (i > 0 && i != 5) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_if_rvalid", i), {31'b0, if_rvalid}, (i == 5) ? 32'd1 : 32'd0);
      if (i == 1) chk("cont1_d_rdata", d_rdata, 32'hC0DE0008);
      tick;
    end
    if_req = 1'b0; d_req = 1'b0;
    settle;
    chk("cont_tail_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("cont_tail_if_rdata", if_rdata, 32'hC0DE000C);

    // Store with partial byte enables, then read it back
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h10; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
    settle;
    chk("st_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("st_mem_we_be", {27'b0, mem_we, mem_be}, 32'h13);
    chk("st_mem_addr", {2'b0, mem_addr}, 32'h10);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick;
    d_we = 1'b0; d_be = 4'b0000;
    settle;
    chk("st_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    tick;
    d_req = 1'b0;
    settle;
    chk("ld_back_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("ld_back_rdata", d_rdata, 32'h1234BEEF);

    // Flush in the response cycle
    tick;
    if_req = 1'b1; if_addr = 30'h14;
    settle;
    chk("fl1_if_gnt", {31'b0, if_gnt}, 32'd1);
    tick;
    if_req = 1'b0; if_flush = 1'b1;
    settle;
    chk("fl1_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    // Flush in the grant cycle
    tick;
    if_req = 1'b1; if_flush = 1'b1;
    settle;
    chk("fl2_if_gnt", {31'b0, if_gnt}, 32'd1);
    tick;
    if_req = 1'b0; if_flush = 1'b0;
    settle;
    chk("fl2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick;
    if_req = 1'b1; if_addr = 30'h18;
    tick;
    if_req = 1'b0;
    settle;
    chk("fl3_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("fl3_if_rdata", if_rdata, 32'hC0DE0018);
    // Flush while only a load is outstanding
    tick;
    d_req = 1'b1; d_addr = 30'h8;
    tick;
    d_req = 1'b0; if_flush = 1'b1;
    settle;
    chk("fl4_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("fl4_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick;
    if_flush = 1'b0;

    // Reset pulsed mid-cycle while a load response is pending, streak at 3
    if_req = 1'b1; d_req = 1'b1; d_addr = 30'h8;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk($sformatf("rs_pre%0d_d_gnt", i), {31'b0, d_gnt}, 32'd1);
      tick;
    end
    #1 reset = 1'b1;
    #1;
    chk("rs_during_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rs_during_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rs_after_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) settle;
      chk($sformatf("rs_post%0d_if_gnt", i), {31'b0, if_gnt}, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("rs_post%0d_d_gnt", i), {31'b0, d_gnt}, (i == 4) ? 32'd0 : 32'd1);
      tick;
    end
    if_req = 1'b0; d_req = 1'b0;
    tick;

    // Alternating load / fetch / load
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h1C;
    settle;
    chk("alt_d_gnt", {31'b0, d_gnt}, 32'd1);
    tick;
    d_req = 1'b0; if_req = 1'b1; if_addr = 30'h20;
    settle;
    chk("alt_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("alt_d_rvalid1", {31'b0, d_rvalid}, 32'd1);
    chk("alt_d_rdata1", d_rdata, 32'hC0DE001C);
    chk("alt_if_rvalid_no", {31'b0, if_rvalid}, 32'd0);
    tick;
    if_req = 1'b0; d_req = 1'b1; d_addr = 30'h24;
    settle;
    chk("alt_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("alt_if_rdata", if_rdata, 32'hC0DE0020);
    chk("alt_d_rvalid_no", {31'b0, d_rvalid}, 32'd0);
    chk("alt_d_gnt2", {31'b0, d_gnt}, 32'd1);
    tick;
    d_req = 1'b0;
    settle;
    chk("alt_d_rvalid2", {31'b0, d_rvalid}, 32'd1);
    chk("alt_d_rdata2", d_rdata, 32'hC0DE0024);
    chk("alt_if_rvalid_no2", {31'b0, if_rvalid}, 32'd0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
